// File: rtl/led_sequencer_if.sv
// Control and LED/status signal bundle for led_sequencer.
// The design side uses the slave modport; whatever drives run/mode uses master.
interface led_sequencer_if #(
    parameter int NUM_LEDS = 4
) ();
    logic                run;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led_g;
    logic [NUM_LEDS-1:0] led_r;
    logic                step_tick;
    logic [1:0]          mode_active;

    modport master (
        output run,
        output mode,
        input  led_g,
        input  led_r,
        input  step_tick,
        input  mode_active
    );

    modport slave (
        input  run,
        input  mode,
        output led_g,
        output led_r,
        output step_tick,
        output mode_active
    );
endinterface

// File: rtl/led_sequencer.sv
// Bi-colour LED sequencer: binary count, bouncing scanner, PWM breathe and off modes, stepped by a prescaler.
// Breathe mode exists only when LED_SEQUENCER_BREATHE_EN is defined; otherwise mode 2 keeps the LEDs dark.
module led_sequencer #(
    parameter int NUM_LEDS    = 4,
    parameter int STEP_CYCLES = 25000000,
    parameter int DUTY_INC    = 8
) (
    input  logic           clk,
    input  logic           rst,
    led_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_W = NUM_LEDS + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    if (NUM_LEDS < 1 || NUM_LEDS > 16 || STEP_CYCLES < 2 || DUTY_INC < 1 || DUTY_INC > 128) begin : gBadParams
        $error("led_sequencer: parameter out of legal range");
    end

    mode_e               modeActive_q, modeActive_d;
    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic                stepTick_q, stepTick_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dirDown_q, dirDown_d;
    logic [NUM_LEDS-1:0] ledG_q, ledG_d;
    logic [NUM_LEDS-1:0] ledR_q, ledR_d;
    logic [NUM_LEDS-1:0] scanOneHot;
`ifdef LED_SEQUENCER_BREATHE_EN
    logic [7:0]          pwm_q, pwm_d;
    logic [7:0]          level_q, level_d;
    logic [8:0]          levelSum;
`endif

    always_comb begin
        modeActive_d = modeActive_q;
        prescaler_d  = prescaler_q;
        stepTick_d   = 1'b0;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        dirDown_d    = dirDown_q;
        ledG_d       = '0;
        ledR_d       = '0;
        scanOneHot   = NUM_LEDS'(1) << pos_q;
`ifdef LED_SEQUENCER_BREATHE_EN
        pwm_d        = pwm_q;
        level_d      = level_q;
        levelSum     = {1'b0, level_q} + 9'(DUTY_INC);
`endif

        case (modeActive_q)
            MODE_COUNT: begin
                if (cnt_q[NUM_LEDS]) begin
                    ledR_d = cnt_q[NUM_LEDS-1:0];
                end else begin
                    ledG_d = cnt_q[NUM_LEDS-1:0];
                end
            end
            MODE_SCAN: begin
                if (dirDown_q) begin
                    ledR_d = scanOneHot;
                end else begin
                    ledG_d = scanOneHot;
                end
            end
`ifdef LED_SEQUENCER_BREATHE_EN
            MODE_BREATHE: ledG_d = {NUM_LEDS{pwm_q < level_q}};
`else
            MODE_BREATHE: ledG_d = '0;
`endif
            default: ;
        endcase

        // A mode change restarts everything from a clean state and swallows any step due this cycle.
        if (bus.mode != modeActive_q) begin
            modeActive_d = mode_e'(bus.mode);
            prescaler_d  = '0;
            cnt_d        = '0;
            pos_d        = '0;
            dirDown_d    = 1'b0;
`ifdef LED_SEQUENCER_BREATHE_EN
            pwm_d        = '0;
            level_d      = '0;
`endif
        end else if (bus.run) begin
`ifdef LED_SEQUENCER_BREATHE_EN
            pwm_d = pwm_q + 8'd1;
`endif
            if (prescaler_q == PRE_LAST) begin
                prescaler_d = '0;
                stepTick_d  = 1'b1;
                case (modeActive_q)
                    MODE_COUNT: cnt_d = cnt_q + CNT_W'(1);
                    MODE_SCAN: begin
                        // dirDown_q names the direction of the move that reached pos_q, so it reverses on leaving an end.
                        if (NUM_LEDS == 1) begin
                            dirDown_d = ~dirDown_q;
                        end else if (!dirDown_q) begin
                            if (pos_q == POS_LAST) begin
                                pos_d     = pos_q - POS_W'(1);
                                dirDown_d = 1'b1;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d     = pos_q + POS_W'(1);
                                dirDown_d = 1'b0;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
`ifdef LED_SEQUENCER_BREATHE_EN
                    MODE_BREATHE: begin
                        if (!dirDown_q) begin
                            if (levelSum >= 9'd255) begin
                                level_d   = 8'hFF;
                                dirDown_d = 1'b1;
                            end else begin
                                level_d = levelSum[7:0];
                            end
                        end else begin
                            if (level_q <= 8'(DUTY_INC)) begin
                                level_d   = '0;
                                dirDown_d = 1'b0;
                            end else begin
                                level_d = level_q - 8'(DUTY_INC);
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end else begin
                prescaler_d = prescaler_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            modeActive_q <= MODE_COUNT;
            prescaler_q  <= '0;
            stepTick_q   <= 1'b0;
            cnt_q        <= '0;
            pos_q        <= '0;
            dirDown_q    <= 1'b0;
            ledG_q       <= '0;
            ledR_q       <= '0;
`ifdef LED_SEQUENCER_BREATHE_EN
            pwm_q        <= '0;
            level_q      <= '0;
`endif
        end else begin
            modeActive_q <= modeActive_d;
            prescaler_q  <= prescaler_d;
            stepTick_q   <= stepTick_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            dirDown_q    <= dirDown_d;
            ledG_q       <= ledG_d;
            ledR_q       <= ledR_d;
`ifdef LED_SEQUENCER_BREATHE_EN
            pwm_q        <= pwm_d;
            level_q      <= level_d;
`endif
        end
    end

    assign bus.led_g       = ledG_q;
    assign bus.led_r       = ledR_q;
    assign bus.step_tick   = stepTick_q;
    assign bus.mode_active = modeActive_q;

endmodule
